// File: rtl/hilo_div_pkg.sv
// +----------------------------------------------------------------------+
// | hilo_div_pkg : shared types and constants for the HI/LO divider      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package hilo_div_pkg;

  typedef logic [31:0] Reg_t;
  typedef logic [63:0] DoubleReg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DBZ  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;
  localparam int   DIV_ITER = 32;

  // Magnitude of an operand; 0x80000000 maps onto itself as an unsigned value.
  function automatic Reg_t abs_if(input Reg_t v, input logic sgn);
    return (sgn && v[31]) ? Reg_t'(-v) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hilo_div_div_step.sv
// +----------------------------------------------------------------------+
// | hilo_div_div_step : one radix-2 restoring-division step              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module hilo_div_div_step #(
  parameter int W = 32
) (
  input  logic [2*W:0] work,
  input  logic [W-1:0] divisor,
  output logic [2*W:0] work_nxt
);

  logic [2*W:0] shifted;
  logic [W:0]   rem_sh;
  logic [W:0]   diff;
  logic         unused_top;

  // The partial remainder stays below the divisor, so the top bit never carries data.
  assign unused_top = work[2*W];

  always_comb begin
    shifted  = {work[2*W-1:0], 1'b0};
    rem_sh   = shifted[2*W:W];
    diff     = rem_sh - {1'b0, divisor};
    work_nxt = shifted;
    if (rem_sh >= {1'b0, divisor}) begin
      work_nxt[2*W:W] = diff;
      work_nxt[0]     = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hilo_div.sv
// +----------------------------------------------------------------------+
// | hilo_div : multi-cycle DIV/DIVU unit writing remainder/quotient to   |
// |            HI/LO with a one-cycle strobe. Rev 1.0                    |
// +----------------------------------------------------------------------+
`default_nettype none

module hilo_div
  import hilo_div_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ITER   = DIV_ITER
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] opdata1_i,
  input  logic [DATA_W-1:0] opdata2_i,
  input  logic              annul_i,
  output logic              busy_o,
  output logic              ready_o,
  output logic              hilo_we_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int              CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  div_state_t        state;
  div_state_t        state_nxt;
  logic              accept;
  logic [2*DATA_W:0] work;
  logic [2*DATA_W:0] work_nxt;
  Reg_t              divisor;
  logic              neg_q;
  logic              neg_r;
  logic [CNT_W-1:0]  count;
  logic              we;
  Reg_t              rem_raw;
  Reg_t              quo_raw;
  DoubleReg_t        result;

  assign accept = (state == IDLE) && (start_i == DivStart) && !annul_i;

  hilo_div_div_step #(.W(DATA_W)) u_step (
    .work     (work),
    .divisor  (divisor),
    .work_nxt (work_nxt)
  );

  // Sign fixups: quotient follows sign mismatch, remainder follows the dividend.
  assign rem_raw = work_nxt[2*DATA_W-1:DATA_W];
  assign quo_raw = work_nxt[DATA_W-1:0];
  assign result  = {(neg_r ? Reg_t'(-rem_raw) : rem_raw),
                    (neg_q ? Reg_t'(-quo_raw) : quo_raw)};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (opdata2_i == '0) ? DBZ : RUN;
      DBZ:  state_nxt = DONE;
      RUN: begin
        if (annul_i)            state_nxt = IDLE;
        else if (count == LAST) state_nxt = DONE;
      end
      DONE: if (annul_i || (start_i == DivStop)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o    = (state == DBZ) || (state == RUN) || accept;
    ready_o   = (state == DONE);
    hilo_we_o = we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work    <= '0;
      divisor <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      count   <= '0;
      we      <= 1'b0;
      hi_o    <= '0;
      lo_o    <= '0;
    end else begin
      we <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && (opdata2_i != '0)) begin
            work    <= {{(DATA_W+1){1'b0}}, abs_if(opdata1_i, signed_i)};
            divisor <= abs_if(opdata2_i, signed_i);
            neg_q   <= signed_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_r   <= signed_i && opdata1_i[DATA_W-1];
            count   <= '0;
          end
        end
        DBZ: begin
          hi_o <= '0;
          lo_o <= '0;
          we   <= 1'b1;
        end
        RUN: begin
          if (!annul_i) begin
            work  <= work_nxt;
            count <= count + 1'b1;
            if (count == LAST) begin
              hi_o <= result[63:32];
              lo_o <= result[31:0];
              we   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hilo_div.sv
// +----------------------------------------------------------------------+
// | tb_hilo_div : randomized bench for hilo_div against an arithmetic    |
// |               reference model. Rev 1.0                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_hilo_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic        busy_o;
  logic        ready_o;
  logic        hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  logic        exp_busy;
  logic        exp_ready;
  logic        exp_we;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;
  logic        chk_en = 1'b0;

  int errors = 0;
  int checks = 0;

  hilo_div dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .annul_i   (annul_i),
    .busy_o    (busy_o),
    .ready_o   (ready_o),
    .hilo_we_o (hilo_we_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // {hi, lo} from plain integer arithmetic; 64-bit math makes the overflow case wrap naturally.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!s) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy_o",    {31'd0, busy_o},    {31'd0, exp_busy});
      chk("ready_o",   {31'd0, ready_o},   {31'd0, exp_ready});
      chk("hilo_we_o", {31'd0, hilo_we_o}, {31'd0, exp_we});
      chk("hi_o",      hi_o,               exp_hi);
      chk("lo_o",      lo_o,               exp_lo);
    end
  end

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input int annul_at, input int hold);
    logic [63:0] r;
    int          lat;
    r   = model(a, b, s);
    lat = (b == 32'd0) ? 2 : 33;
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = s; opdata1_i = a; opdata2_i = b;
    exp_busy = 1'b1;
    for (int c = 1; c < lat; c++) begin
      @(posedge clk); #1;
      opdata1_i = $urandom; opdata2_i = $urandom; signed_i = 1'($urandom);
      if (annul_at >= 0 && b != 32'd0 && c == annul_at + 1) begin
        start_i = 1'b0; annul_i = 1'b1;
        @(posedge clk); #1;
        annul_i  = 1'b0;
        exp_busy = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    exp_busy = 1'b0; exp_ready = 1'b1; exp_we = 1'b1;
    exp_hi = r[63:32]; exp_lo = r[31:0];
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      exp_we = 1'b0;
    end
    @(posedge clk); #1;
    start_i = 1'b0; exp_we = 1'b0;
    @(posedge clk); #1;
    exp_ready = 1'b0;
  endtask

  task automatic reset_mid(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = a; opdata2_i = b;
    exp_busy = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    start_i = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_busy = 1'b0; exp_ready = 1'b0; exp_we = 1'b0; exp_hi = '0; exp_lo = '0;
    repeat (40) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [63:0] p;
    logic [31:0] a, b;
    int          annul_at;

    p = model(32'd100, 32'd7, 1'b0);
    chk("model_divu_100_7", p[63:32] ^ p[31:0], 32'h2 ^ 32'hE);
    chk("model_divu_100_7_lo", p[31:0], 32'h0000000E);
    p = model(32'hFFFFFFF9, 32'h2, 1'b1);
    chk("model_div_m7_2_lo", p[31:0], 32'hFFFFFFFD);
    chk("model_div_m7_2_hi", p[63:32], 32'hFFFFFFFF);
    p = model(32'h7, 32'hFFFFFFFE, 1'b1);
    chk("model_div_7_m2_hi", p[63:32], 32'h00000001);
    p = model(32'h80000000, 32'hFFFFFFFF, 1'b1);
    chk("model_div_ovf_lo", p[31:0], 32'h80000000);
    chk("model_div_ovf_hi", p[63:32], 32'h00000000);
    p = model(32'h80000000, 32'hFFFFFFFF, 1'b0);
    chk("model_divu_ovf_hi", p[63:32], 32'h80000000);

    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    exp_busy = 1'b0; exp_ready = 1'b0; exp_we = 1'b0; exp_hi = '0; exp_lo = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;

    do_op(32'd100, 32'd7, 1'b0, -1, 0);
    do_op(32'hFFFFFFF9, 32'h2, 1'b1, -1, 0);
    do_op(32'h7, 32'hFFFFFFFE, 1'b1, -1, 1);
    do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, -1, 0);
    do_op(32'h80000000, 32'hFFFFFFFF, 1'b0, -1, 0);
    do_op(32'd5, 32'd0, 1'b0, -1, 0);
    do_op(32'hFFFFFFFF, 32'd3, 1'b0, 10, 0);
    do_op(32'd9, 32'd3, 1'b0, -1, 0);
    do_op(32'd1234567, 32'd89, 1'b0, -1, 5);

    // Start with annul in IDLE must be ignored.
    @(posedge clk); #1;
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
    @(posedge clk); #1;
    start_i = 1'b0; annul_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    reset_mid(32'hDEADBEEF, 32'd17);

    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        2:       b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      annul_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : -1;
      do_op(a, b, 1'($urandom), annul_at, int'($urandom_range(0, 3)));
    end

    repeat (2) begin @(posedge clk); #1; end
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hilo_div.md
Name: hilo_div

Overview:
- Multi-cycle 32-bit integer divider: the write-side producer for the HI/LO register pair.
- Executes DIV/DIVU issued from EX and returns remainder to HI and quotient to LO through a one-cycle write strobe.
- Requests a pipeline stall while busy.
- Sits beside the EX stage; its hilo write port feeds the HI/LO register's we/hi/lo inputs through the EX/MEM/WB path.

Parameters:
- DATA_W, 32, operand and result half-width (fixed to Reg_t width).
- ITER, 32, number of restoring-division iterations (equals DATA_W).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start_i  in  1  division request; held high by EX until ready_o seen
- signed_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  32  dividend (Reg_t)
- opdata2_i  in  32  divisor (Reg_t)
- annul_i  in  1  cancel in-flight division (exception/flush)
- busy_o  in  1 → out  1  stall request to pipeline control
- ready_o  out  1  result valid
- hilo_we_o  out  1  one-cycle HI/LO write strobe
- hi_o  out  32  remainder (Reg_t)
- lo_o  out  32  quotient (Reg_t)

Behaviour:
- Reset: state IDLE; busy_o, ready_o, hilo_we_o = 0; hi_o, lo_o = 0. Reset mid-operation aborts with no write.
- States: IDLE, DBZ, RUN, DONE.
- IDLE:
  - start_i=1, annul_i=0, divisor=0 → DBZ.
  - start_i=1, annul_i=0, divisor≠0 → latch |dividend|, |divisor|, sign flags; counter=0; → RUN.
  - start_i=1 with annul_i=1 is ignored.
- DBZ: one cycle → DONE with hi=0, lo=0.
- RUN:
  - Per cycle: 65-bit shift register {rem, quo}. Shift left 1. If rem ≥ divisor, subtract and set quo LSB.
  - counter increments; after the 32nd iteration → DONE.
  - annul_i=1 in RUN → IDLE next cycle, no write, outputs unchanged.
- DONE:
  - Signed fixups applied on entry:
    - quotient negated if operand signs differ;
    - remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF signed yields q=0x80000000, r=0; two's-complement wrap, no trap.
  - ready_o=1 for as long as state stays DONE.
  - hilo_we_o=1 only on the first DONE cycle.
  - Stays in DONE while start_i=1, so a held start never re-triggers or rewrites. start_i=0 → IDLE.
  - annul_i in DONE → IDLE; any write already issued stands.
- busy_o = 1 in DBZ and RUN. It is also 1 in IDLE on the cycle start_i is accepted (combinational), so EX stalls from the request cycle.
- Latency, with start accepted at cycle N:
  - nonzero divisor: ready_o and hilo_we_o at N+33;
  - zero divisor: ready_o and hilo_we_o at N+2.
- hi_o/lo_o hold their last result until the next DONE entry.
- Unsigned operands use raw values. Absolute value of 0x80000000 is the unsigned 0x80000000.

Decomposition:
- Shared package (alongside defines.svh): Reg_t, DoubleReg_t (64-bit), div_state_t enum {IDLE, DBZ, RUN, DONE}, DivStart/DivStop constants, DIV_ITER=32.
- One combinational sub-module is natural: div_step. It takes the 65-bit working register and divisor and returns the next working register. It is reusable for a radix-4 variant later.

Test Plan:
1. DIVU 100/7 (0x64/0x7) → ready_o and hilo_we_o at N+33; hilo_we_o pulses exactly one cycle; lo_o=0x0000000E, hi_o=0x00000002; busy_o high N..N+32.
2. DIV -7/2 (0xFFFFFFF9/0x00000002) → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. Also DIV 7/-2 → lo_o=0xFFFFFFFD, hi_o=0x00000001.
3. DIV 0x80000000/0xFFFFFFFF → lo_o=0x80000000, hi_o=0x00000000; no hang. DIVU of same operands → lo_o=0x00000000, hi_o=0x80000000.
4. DIVU 5/0 → DBZ path; ready_o and hilo_we_o at N+2; hi_o=lo_o=0.
5. DIVU 0xFFFFFFFF/3, annul_i at iteration 10 → IDLE next cycle, no hilo_we_o, busy_o drops. Then DIVU 9/3 → lo_o=3, hi_o=0 at +33.
6. start_i held 5 cycles after ready_o → single hilo_we_o pulse, ready_o high throughout. Then rst asserted mid-RUN of a second op → all outputs 0 next cycle, no write.
